sha_256: RTL and testbench

- Parameterised SHA-256 (FIPS 180-4) hash core.
- Takes a fixed-width message on a parallel bus and pads it internally to PADDED_SIZE bits.
- Processes one 512-bit block at a time, one compression round per clock, and presents the 256-bit digest on a parallel output.
- Standalone leaf block; by default hashing starts automatically after reset release.

---
 rtl/sha_256_pkg.sv | 93 +++++++++
 rtl/sha_256_round.sv | 32 +++
 rtl/sha_256.sv | 144 ++++++++++++++
 tb/tb_sha_256.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_256_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_256_pkg
// Description : SHA-256 round constants, IV, FSM state type and the
//               FIPS 180-4 logical functions shared by the core.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Working set a..h; packing order puts a at the MSBs so {H0..H7} is a direct cast.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam work_t c_iv = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Trailing 64-bit message-length field of the padded message.
    function automatic logic [63:0] length_field(input int unsigned msg_bits);
        return 64'(msg_bits);
    endfunction

    function automatic work_t add_work(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha_256_round.sv
`default_nettype none
// ============================================================================
// Module      : sha_256_round
// Description : One combinational SHA-256 compression round.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_256_round
    import sha_256_pkg::*;
(
    input  work_t       i_work,
    input  logic [31:0] i_k,
    input  logic [31:0] i_w,
    output work_t       o_work
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = i_work.h + big_sigma1(i_work.e) + ch(i_work.e, i_work.f, i_work.g) + i_k + i_w;
    assign w_t2 = big_sigma0(i_work.a) + maj(i_work.a, i_work.b, i_work.c);

    assign o_work.a = w_t1 + w_t2;
    assign o_work.b = i_work.a;
    assign o_work.c = i_work.b;
    assign o_work.d = i_work.c;
    assign o_work.e = i_work.d + w_t1;
    assign o_work.f = i_work.e;
    assign o_work.g = i_work.f;
    assign o_work.h = i_work.g;

endmodule
`default_nettype wire

// File: rtl/sha_256.sv
`default_nettype none
// ============================================================================
// Module      : sha_256
// Description : SHA-256 core, one round per clock, internal padding of a
//               fixed-width message. Optional macro SHA_256_START_EN adds a
//               start input for repeated hashing; otherwise a single run
//               begins automatically after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_256
    import sha_256_pkg::*;
#(
    parameter int MSG_SIZE    = 24,
    parameter int PADDED_SIZE = 512
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SHA_256_START_EN
    input  logic                start,
`endif
    input  logic [MSG_SIZE-1:0] message,
    output logic [255:0]        hashed,
    output logic                done
);

    localparam int c_n_blocks = PADDED_SIZE / 512;
    localparam int c_blk_w    = (c_n_blocks > 1) ? $clog2(c_n_blocks) : 1;
    localparam int c_zero_w   = PADDED_SIZE - MSG_SIZE - 65;

    if (MSG_SIZE < 1 || (PADDED_SIZE % 512) != 0 || PADDED_SIZE < MSG_SIZE + 65) begin : g_param_check
        $error("sha_256: MSG_SIZE/PADDED_SIZE combination is invalid");
    end

    logic [PADDED_SIZE-1:0] w_padded;

    if (c_zero_w > 0) begin : g_pad_zeros
        assign w_padded = {message, 1'b1, {c_zero_w{1'b0}}, length_field(MSG_SIZE)};
    end else begin : g_pad_tight
        assign w_padded = {message, 1'b1, length_field(MSG_SIZE)};
    end

    state_t                 r_state;
    logic [PADDED_SIZE-1:0] r_padded;
    work_t                  r_hash;
    work_t                  r_work;
    logic [31:0]            r_w [0:15];
    logic [5:0]             r_round;
    logic [c_blk_w-1:0]     r_block;

    logic                   w_start_idle;
    logic                   w_start_done;
    logic                   w_do_load;
    work_t                  w_round_out;
    work_t                  w_hash_sum;
    logic [31:0]            w_w_new;
    logic [PADDED_SIZE-1:0] w_next_padded;
    logic [511:0]           w_first_blk;
    logic [511:0]           w_next_blk;

`ifdef SHA_256_START_EN
    assign w_start_idle = start;
    assign w_start_done = start;
`else
    assign w_start_idle = 1'b1;
    assign w_start_done = 1'b0;
`endif

    always_comb begin
        w_do_load = 1'b0;
        if (r_state == ST_IDLE) begin
            w_do_load = w_start_idle;
        end else if (r_state == ST_DONE) begin
            w_do_load = w_start_done;
        end
    end

    // r_padded keeps the not-yet-consumed blocks left-aligned, so the next block is always on top.
    assign w_next_padded = r_padded << 512;
    assign w_first_blk   = w_padded[PADDED_SIZE-1 -: 512];
    assign w_next_blk    = w_next_padded[PADDED_SIZE-1 -: 512];
    assign w_hash_sum    = add_work(r_hash, r_work);
    assign w_w_new       = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

    sha_256_round u_round (
        .i_work (r_work),
        .i_k    (c_k[r_round]),
        .i_w    (r_w[0]),
        .o_work (w_round_out)
    );

    // The load is performed on the edge entering LOAD, so LOAD already executes round 0
    // and every block costs 64 rounds plus one UPDATE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_padded <= '0;
            r_hash   <= '0;
            r_work   <= '0;
            r_round  <= '0;
            r_block  <= '0;
            hashed   <= '0;
            done     <= 1'b0;
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else if (w_do_load) begin
            r_state  <= ST_LOAD;
            r_padded <= w_padded;
            r_hash   <= c_iv;
            r_work   <= c_iv;
            r_round  <= '0;
            r_block  <= '0;
            done     <= 1'b0;
            for (int i = 0; i < 16; i++) r_w[i] <= w_first_blk[511-32*i -: 32];
        end else begin
            case (r_state)
                ST_LOAD, ST_ROUND: begin
                    r_work  <= w_round_out;
                    r_round <= r_round + 6'd1;
                    for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
                    r_w[15] <= w_w_new;
                    r_state <= (r_round == 6'd63) ? ST_UPDATE : ST_ROUND;
                end
                ST_UPDATE: begin
                    r_hash <= w_hash_sum;
                    if (r_block != c_blk_w'(c_n_blocks - 1)) begin
                        r_block  <= r_block + 1'b1;
                        r_padded <= w_next_padded;
                        r_work   <= w_hash_sum;
                        r_round  <= '0;
                        for (int i = 0; i < 16; i++) r_w[i] <= w_next_blk[511-32*i -: 32];
                        r_state  <= ST_ROUND;
                    end else begin
                        hashed  <= w_hash_sum;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_IDLE, ST_DONE: r_state <= r_state;
                default:          r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha_256.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_256
// Description : Directed self-checking bench for sha_256 ("abc", a 26-byte
//               string, the two-block 448-bit vector, aborts and restarts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_256;

    localparam logic [255:0] c_abc_digest  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_long_digest = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] c_k_ref [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] c_iv_ref [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic         clk;
    logic         rst;
    logic [23:0]  msg_abc;
    logic [207:0] msg_lor;
    logic [447:0] msg_long;
    logic [255:0] hashed_abc, hashed_lor, hashed_long;
    logic         done_abc, done_lor, done_long;
`ifdef SHA_256_START_EN
    logic         start;
`endif

    int n_assert;
    int n_fail;
    int first_abc, first_lor, first_long, leak, idle_done;

    sha_256 #(.MSG_SIZE(24), .PADDED_SIZE(512)) u_abc (
        .clk     (clk),
        .rst     (rst),
`ifdef SHA_256_START_EN
        .start   (start),
`endif
        .message (msg_abc),
        .hashed  (hashed_abc),
        .done    (done_abc)
    );

    sha_256 #(.MSG_SIZE(208), .PADDED_SIZE(512)) u_lor (
        .clk     (clk),
        .rst     (rst),
`ifdef SHA_256_START_EN
        .start   (start),
`endif
        .message (msg_lor),
        .hashed  (hashed_lor),
        .done    (done_lor)
    );

    sha_256 #(.MSG_SIZE(448), .PADDED_SIZE(1024)) u_long (
        .clk     (clk),
        .rst     (rst),
`ifdef SHA_256_START_EN
        .start   (start),
`endif
        .message (msg_long),
        .hashed  (hashed_long),
        .done    (done_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 for single-block messages of len bits, right-aligned in msg.
    function automatic logic [255:0] sha_model(input logic [447:0] msg, input int len);
        logic [511:0] blk;
        logic [31:0]  w [0:63];
        logic [31:0]  v [0:7];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        blk = '0;
        for (int i = 0; i < len; i++) blk[511-i] = msg[len-1-i];
        blk[511-len] = 1'b1;
        blk[63:0] = 64'(len);
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = c_iv_ref[i];
        for (int t = 0; t < 64; t++) begin
            s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_k_ref[t] + w[t];
            s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = c_iv_ref[i] + v[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic release_rst();
`ifdef SHA_256_START_EN
        start = 1'b1;
`endif
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Watches n_edges rising edges, recording the first edge with done high per DUT.
    task automatic observe(input int n_edges, input int change_at);
        first_abc = 0; first_lor = 0; first_long = 0; leak = 0;
        for (int e = 1; e <= n_edges; e++) begin
            @(posedge clk);
            #1;
`ifdef SHA_256_START_EN
            if (e == 1) start = 1'b0;
`endif
            if (e == change_at) msg_abc = "abd";
            if (done_abc  && first_abc  == 0) first_abc  = e;
            if (done_lor  && first_lor  == 0) first_lor  = e;
            if (done_long && first_long == 0) first_long = e;
            if ((!done_abc && hashed_abc != '0) || (!done_lor && hashed_lor != '0) ||
                (!done_long && hashed_long != '0)) leak++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
`ifdef SHA_256_START_EN
        start    = 1'b0;
`endif
        msg_abc  = "abc";
        msg_lor  = "lorem ipsum dolor sit amet";
        msg_long = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        #3;
        check("reset_done_abc",    256'(done_abc),  256'd0);
        check("reset_hashed_abc",  hashed_abc,      256'd0);
        check("reset_done_lor",    256'(done_lor),  256'd0);
        check("reset_hashed_lor",  hashed_lor,      256'd0);
        check("reset_done_long",   256'(done_long), 256'd0);
        check("reset_hashed_long", hashed_long,     256'd0);

        release_rst();
        observe(140, 0);
        check("abc_done_edge",    256'(first_abc),  256'd66);
        check("abc_digest",       hashed_abc,       c_abc_digest);
        check("lorem_done_edge",  256'(first_lor),  256'd66);
        check("lorem_digest",     hashed_lor,       sha_model({240'd0, msg_lor}, 208));
        $display("lorem digest = %h", hashed_lor);
        check("long_done_edge",   256'(first_long), 256'd131);
        check("long_digest",      hashed_long,      c_long_digest);
        check("no_early_output",  256'(leak),       256'd0);

        // Reset asserted away from any clock edge while holding a digest.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_done_abc",   256'(done_abc),  256'd0);
        check("async_rst_hashed_abc", hashed_abc,      256'd0);
        check("async_rst_done_long",  256'(done_long), 256'd0);

        release_rst();
        observe(29, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_done_abc",   256'(done_abc), 256'd0);
        check("abort_hashed_abc", hashed_abc,     256'd0);

        release_rst();
        observe(70, 10);
        check("rerun_done_edge",    256'(first_abc), 256'd66);
        check("msg_change_ignored", hashed_abc,      c_abc_digest);
        check("rerun_no_early",     256'(leak),      256'd0);
        msg_abc = "abc";

`ifdef SHA_256_START_EN
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_done = 0;
        for (int e = 0; e < 200; e++) begin
            @(posedge clk);
            #1;
            if (done_abc) idle_done++;
        end
        check("idle_without_start", 256'(idle_done), 256'd0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        observe(80, 0);
        check("start_done_edge", 256'(first_abc), 256'd65);
        check("start_digest",    hashed_abc,      c_abc_digest);

        @(negedge clk);
        msg_abc = "abd";
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_clears_done", 256'(done_abc), 256'd0);
        check("restart_keeps_hash",  hashed_abc,     c_abc_digest);
        observe(80, 0);
        check("restart_done_edge", 256'(first_abc), 256'd65);
        check("restart_digest",    hashed_abc,      sha_model({424'd0, 24'h616264}, 24));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
